// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle MIPS controller slice:
//   - opcode / funct field values of every supported instruction
//   - FSM state encoding (also exported on the debug state port)
//   - datapath mux codes (npcSel, toReg, grfSlt, extOp, aluOp, mdOp)
//   - decode_t, the bundle produced by mc_decoder for one instruction
// No ports; imported by every other file of the block.
// ---------------------------------------------------------------------------
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MDWAIT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JAL    = 2'd2,
    NPC_JR     = 2'd3
  } npcSel_e;

  typedef enum logic [1:0] {
    TOREG_ALU  = 2'd0,
    TOREG_DM   = 2'd1,
    TOREG_PC   = 2'd2,
    TOREG_HILO = 2'd3
  } toReg_e;

  typedef enum logic [1:0] {
    GRF_RT = 2'd0,
    GRF_RD = 2'd1,
    GRF_RA = 2'd2
  } grfSlt_e;

  typedef enum logic [1:0] {
    EXT_SIGN     = 2'd0,
    EXT_ZERO     = 2'd1,
    EXT_SIGN_SH2 = 2'd2,
    EXT_LUI      = 2'd3
  } extOp_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } aluOp_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdOp_e;

  typedef struct packed {
    logic    isAddu;
    logic    isSubu;
    logic    isOri;
    logic    isLw;
    logic    isSw;
    logic    isBeq;
    logic    isLui;
    logic    isJal;
    logic    isJr;
    logic    isMult;
    logic    isMultu;
    logic    isDiv;
    logic    isDivu;
    logic    isMfhi;
    logic    isMflo;
    logic    isUnknown;
    aluOp_e  aluOp;
    logic    aluB;
    extOp_e  extOp;
    mdOp_e   mdOp;
    grfSlt_e grfSlt;
    toReg_e  toReg;
    logic    hiloSel;
  } decode_t;

  // Any of the four HI/LO arithmetic instructions that go through MDWAIT.
  function automatic logic isMulDiv(decode_t d);
    return d.isMult | d.isMultu | d.isDiv | d.isDivu;
  endfunction

endpackage

// File: rtl/mc_if.sv
// ---------------------------------------------------------------------------
// mc_if
// Groups the controller's instruction inputs and datapath control outputs.
//   master : controller side (drives enables/selects, reads instr/zero)
//   slave  : datapath side   (drives instr/zero, reads enables/selects)
// Signals: instr[31:0], zero, irWE, pcWE, npcSel[1:0], grfWE, grfSlt[1:0],
//          toReg[1:0], hiloSel, extOp[1:0], aluOp[1:0], aluB, dmWE,
//          mdStart, mdOp[1:0], mdBusy, state[2:0].
// ---------------------------------------------------------------------------
interface mc_if;
  logic [31:0] instr;
  logic        zero;
  logic        irWE;
  logic        pcWE;
  logic [1:0]  npcSel;
  logic        grfWE;
  logic [1:0]  grfSlt;
  logic [1:0]  toReg;
  logic        hiloSel;
  logic [1:0]  extOp;
  logic [1:0]  aluOp;
  logic        aluB;
  logic        dmWE;
  logic        mdStart;
  logic [1:0]  mdOp;
  logic        mdBusy;
  logic [2:0]  state;

  modport master (
    input  instr, zero,
    output irWE, pcWE, npcSel, grfWE, grfSlt, toReg, hiloSel,
           extOp, aluOp, aluB, dmWE, mdStart, mdOp, mdBusy, state
  );

  modport slave (
    output instr, zero,
    input  irWE, pcWE, npcSel, grfWE, grfSlt, toReg, hiloSel,
           extOp, aluOp, aluB, dmWE, mdStart, mdOp, mdBusy, state
  );
endinterface

// File: rtl/mc_decoder.sv
// ---------------------------------------------------------------------------
// mc_decoder
// Purely combinational instruction decoder.
//   opcode_i[5:0] : instr[31:26]
//   funct_i[5:0]  : instr[5:0]
//   dec_o         : one-hot instruction class flags plus the per-instruction
//                   ALU/EXT/HI-LO/writeback fields (decode_t)
// ---------------------------------------------------------------------------
module mc_decoder
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output decode_t    dec_o
);

  logic rtype;
  logic isAddu, isSubu, isOri, isLw, isSw, isBeq, isLui, isJal, isJr;
  logic isMult, isMultu, isDiv, isDivu, isMfhi, isMflo;

  assign rtype   = (opcode_i == OP_RTYPE);
  assign isAddu  = rtype && (funct_i == FN_ADDU);
  assign isSubu  = rtype && (funct_i == FN_SUBU);
  assign isMult  = rtype && (funct_i == FN_MULT);
  assign isMultu = rtype && (funct_i == FN_MULTU);
  assign isDiv   = rtype && (funct_i == FN_DIV);
  assign isDivu  = rtype && (funct_i == FN_DIVU);
  assign isMfhi  = rtype && (funct_i == FN_MFHI);
  assign isMflo  = rtype && (funct_i == FN_MFLO);
  assign isJr    = rtype && (funct_i == FN_JR);
  assign isOri   = (opcode_i == OP_ORI);
  assign isLw    = (opcode_i == OP_LW);
  assign isSw    = (opcode_i == OP_SW);
  assign isBeq   = (opcode_i == OP_BEQ);
  assign isLui   = (opcode_i == OP_LUI);
  assign isJal   = (opcode_i == OP_JAL);

  // Pack the class flags and derive the datapath fields. These fields depend
  // only on the instruction, so they stay constant for as long as the IR
  // holds it, which covers EXEC, MEM and WB without any extra registers.
  always_comb begin
    dec_o           = '0;
    dec_o.isAddu    = isAddu;
    dec_o.isSubu    = isSubu;
    dec_o.isOri     = isOri;
    dec_o.isLw      = isLw;
    dec_o.isSw      = isSw;
    dec_o.isBeq     = isBeq;
    dec_o.isLui     = isLui;
    dec_o.isJal     = isJal;
    dec_o.isJr      = isJr;
    dec_o.isMult    = isMult;
    dec_o.isMultu   = isMultu;
    dec_o.isDiv     = isDiv;
    dec_o.isDivu    = isDivu;
    dec_o.isMfhi    = isMfhi;
    dec_o.isMflo    = isMflo;
    dec_o.isUnknown = ~(isAddu | isSubu | isOri | isLw | isSw | isBeq |
                        isLui | isJal | isJr | isMult | isMultu | isDiv |
                        isDivu | isMfhi | isMflo);

    if (isSubu || isBeq) begin
      dec_o.aluOp = ALU_SUB;
    end else if (isOri) begin
      dec_o.aluOp = ALU_OR;
    end else begin
      dec_o.aluOp = ALU_ADD;
    end

    dec_o.aluB = isOri | isLw | isSw | isLui;

    if (isOri) begin
      dec_o.extOp = EXT_ZERO;
    end else if (isLui) begin
      dec_o.extOp = EXT_LUI;
    end else if (isBeq) begin
      dec_o.extOp = EXT_SIGN_SH2;
    end else begin
      dec_o.extOp = EXT_SIGN;
    end

    if (isMultu) begin
      dec_o.mdOp = MD_MULTU;
    end else if (isDiv) begin
      dec_o.mdOp = MD_DIV;
    end else if (isDivu) begin
      dec_o.mdOp = MD_DIVU;
    end else begin
      dec_o.mdOp = MD_MULT;
    end

    if (isJal) begin
      dec_o.grfSlt = GRF_RA;
    end else if (isAddu || isSubu || isMfhi || isMflo) begin
      dec_o.grfSlt = GRF_RD;
    end else begin
      dec_o.grfSlt = GRF_RT;
    end

    if (isJal) begin
      dec_o.toReg = TOREG_PC;
    end else if (isLw) begin
      dec_o.toReg = TOREG_DM;
    end else if (isMfhi || isMflo) begin
      dec_o.toReg = TOREG_HILO;
    end else begin
      dec_o.toReg = TOREG_ALU;
    end

    dec_o.hiloSel = isMfhi;
  end

endmodule

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multi-cycle MIPS controller: sequences each instruction held in the IR
// through FETCH/DECODE/EXEC/MEM/WB (and MDWAIT for mult/div), asserting the
// datapath enables for each state.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; also masks every write enable
//   bus   : mc_if.master -- instr/zero in, all datapath controls out
// Parameters:
//   MULT_CYCLES : MDWAIT length for mult/multu (>= 1)
//   DIV_CYCLES  : MDWAIT length for div/divu   (>= 1)
//   CNT_W       : MD countdown width, 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES)
// ---------------------------------------------------------------------------
module mc_controller
  import mc_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] mdCnt_q, mdCnt_d;
  decode_t          dec;

  logic    rawIrWE, rawPcWE, rawGrfWE, rawDmWE, rawMdStart, rawMdBusy;
  npcSel_e npcSel;

  mc_decoder u_decoder (
    .opcode_i (bus.instr[31:26]),
    .funct_i  (bus.instr[5:0]),
    .dec_o    (dec)
  );

  // State register and MD countdown. Reset returns to FETCH from anywhere,
  // including mid-MDWAIT, and clears the counter so a stale count can never
  // shorten the next multiply/divide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      mdCnt_q <= '0;
    end else begin
      state_q <= state_d;
      mdCnt_q <= mdCnt_d;
    end
  end

  // Next-state and per-state enables. Every enable defaults low so any state
  // or instruction that does not explicitly ask for a write behaves as a nop.
  // MDWAIT counts down from N-1 to 0, which keeps it for exactly N cycles.
  always_comb begin
    state_d    = ST_FETCH;
    mdCnt_d    = mdCnt_q;
    rawIrWE    = 1'b0;
    rawPcWE    = 1'b0;
    rawGrfWE   = 1'b0;
    rawDmWE    = 1'b0;
    rawMdStart = 1'b0;
    rawMdBusy  = 1'b0;
    npcSel     = NPC_PC4;

    case (state_q)
      ST_FETCH: begin
        rawIrWE = 1'b1;
        rawPcWE = 1'b1;
        npcSel  = NPC_PC4;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        if (dec.isJal) begin
          rawGrfWE = 1'b1;
          rawPcWE  = 1'b1;
          npcSel   = NPC_JAL;
          state_d  = ST_FETCH;
        end else if (dec.isJr) begin
          rawPcWE = 1'b1;
          npcSel  = NPC_JR;
          state_d = ST_FETCH;
        end else if (dec.isUnknown) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (dec.isBeq) begin
          rawPcWE = bus.zero;
          npcSel  = NPC_BRANCH;
          state_d = ST_FETCH;
        end else if (dec.isLw || dec.isSw) begin
          state_d = ST_MEM;
        end else if (isMulDiv(dec)) begin
          rawMdStart = 1'b1;
          if (dec.isDiv || dec.isDivu) begin
            mdCnt_d = CNT_W'(DIV_CYCLES - 1);
          end else begin
            mdCnt_d = CNT_W'(MULT_CYCLES - 1);
          end
          state_d = ST_MDWAIT;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        if (dec.isSw) begin
          rawDmWE = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        rawGrfWE = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_MDWAIT: begin
        rawMdBusy = 1'b1;
        if (mdCnt_q == '0) begin
          state_d = ST_FETCH;
        end else begin
          mdCnt_d = mdCnt_q - CNT_W'(1);
          state_d = ST_MDWAIT;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Output mux. Write enables and the MD start pulse are masked by reset so
  // an interrupted instruction cannot commit anything in the reset cycle;
  // the mux selects come straight from the decoder and are held for as long
  // as the IR holds the instruction.
  assign bus.irWE    = rawIrWE    & ~reset;
  assign bus.pcWE    = rawPcWE    & ~reset;
  assign bus.grfWE   = rawGrfWE   & ~reset;
  assign bus.dmWE    = rawDmWE    & ~reset;
  assign bus.mdStart = rawMdStart & ~reset;
  assign bus.mdBusy  = rawMdBusy;
  assign bus.npcSel  = npcSel;
  assign bus.grfSlt  = dec.grfSlt;
  assign bus.toReg   = dec.toReg;
  assign bus.hiloSel = dec.hiloSel;
  assign bus.extOp   = dec.extOp;
  assign bus.aluOp   = dec.aluOp;
  assign bus.aluB    = dec.aluB;
  assign bus.mdOp    = dec.mdOp;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
// Directed, table-driven bench for mc_controller (MULT_CYCLES=5,
// DIV_CYCLES=10). Each table row is one clock cycle: inputs to drive and the
// expected state / write-enable vector / npcSel, plus an optional index into
// a table of per-instruction datapath selects checked in that cycle.
// ---------------------------------------------------------------------------
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset;

  mc_if bus();

  mc_controller #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock; inputs change and outputs are sampled
  // around the falling edge, well away from the rising edge.
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          rst;
    logic [31:0] ins;
    bit          z;
    logic [2:0]  st;
    logic [5:0]  en;
    int          npc;
    int          sIdx;
  } row_t;

  typedef struct {
    string nm;
    int    grfSlt;
    int    toReg;
    int    hiloSel;
    int    extOp;
    int    aluOp;
    int    aluB;
    int    mdOp;
  } sel_t;

  row_t rows[$];
  sel_t sels[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] iAddu, iSubu, iOri, iLui, iLw, iSw, iBeq, iJal, iJr;
  logic [31:0] iMult, iDiv, iDivu, iMfhi, iMflo, iBad;

  function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // One comparison; prints a FAIL line on mismatch.
  task automatic checkVal(string what, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0d want=%0d", what, act, exp);
    end
  endtask

  task automatic addRow(string nm, bit r, logic [31:0] ins, bit z,
                        logic [2:0] st, logic [5:0] en, int npc, int sIdx);
    row_t x;
    x.nm = nm; x.rst = r; x.ins = ins; x.z = z;
    x.st = st; x.en = en; x.npc = npc; x.sIdx = sIdx;
    rows.push_back(x);
  endtask

  task automatic addSel(string nm, int g, int t, int h, int e, int a, int b, int m);
    sel_t s;
    s.nm = nm; s.grfSlt = g; s.toReg = t; s.hiloSel = h;
    s.extOp = e; s.aluOp = a; s.aluB = b; s.mdOp = m;
    sels.push_back(s);
  endtask

  // Enable vector order: {irWE, pcWE, grfWE, dmWE, mdStart, mdBusy}
  task automatic addFetch(string nm, logic [31:0] ins);
    addRow({nm, ".F"}, 1'b0, ins, 1'b0, 3'd0, 6'b110000, 0, -1);
  endtask

  task automatic addAluSeq(string nm, logic [31:0] ins, int sIdx);
    addFetch(nm, ins);
    addRow({nm, ".D"}, 1'b0, ins, 1'b0, 3'd1, 6'b000000, -1, -1);
    addRow({nm, ".E"}, 1'b0, ins, 1'b0, 3'd2, 6'b000000, -1, -1);
    addRow({nm, ".W"}, 1'b0, ins, 1'b0, 3'd4, 6'b001000, -1, sIdx);
  endtask

  task automatic addMdSeq(string nm, logic [31:0] ins, int sIdx, int n);
    addFetch(nm, ins);
    addRow({nm, ".D"}, 1'b0, ins, 1'b0, 3'd1, 6'b000000, -1, -1);
    addRow({nm, ".E"}, 1'b0, ins, 1'b0, 3'd2, 6'b000010, -1, sIdx);
    for (int k = 0; k < n; k++)
      addRow($sformatf("%s.MD%0d", nm, k), 1'b0, ins, 1'b0, 3'd5, 6'b000001, -1, -1);
  endtask

  task automatic applyStimulus(row_t r);
    reset     = r.rst;
    bus.instr = r.ins;
    bus.zero  = r.z;
  endtask

  task automatic checkOutput(row_t r);
    sel_t s;
    checkVal({r.nm, ".state"}, int'(bus.state), int'(r.st));
    checkVal({r.nm, ".en"},
             int'({bus.irWE, bus.pcWE, bus.grfWE, bus.dmWE, bus.mdStart, bus.mdBusy}),
             int'(r.en));
    if (r.npc >= 0)
      checkVal({r.nm, ".npcSel"}, int'(bus.npcSel), r.npc);
    if (r.sIdx >= 0) begin
      s = sels[r.sIdx];
      if (s.grfSlt  >= 0) checkVal({r.nm, ".grfSlt"},  int'(bus.grfSlt),  s.grfSlt);
      if (s.toReg   >= 0) checkVal({r.nm, ".toReg"},   int'(bus.toReg),   s.toReg);
      if (s.hiloSel >= 0) checkVal({r.nm, ".hiloSel"}, int'(bus.hiloSel), s.hiloSel);
      if (s.extOp   >= 0) checkVal({r.nm, ".extOp"},   int'(bus.extOp),   s.extOp);
      if (s.aluOp   >= 0) checkVal({r.nm, ".aluOp"},   int'(bus.aluOp),   s.aluOp);
      if (s.aluB    >= 0) checkVal({r.nm, ".aluB"},    int'(bus.aluB),    s.aluB);
      if (s.mdOp    >= 0) checkVal({r.nm, ".mdOp"},    int'(bus.mdOp),    s.mdOp);
    end
  endtask

  // Build the tables, hold reset for two cycles, then walk the rows one
  // clock cycle each and print the summary.
  initial begin
    iAddu = rtype(1, 2, 3, 6'b100001);
    iSubu = rtype(1, 2, 8, 6'b100011);
    iOri  = itype(6'b001101, 1, 6, 16'h00ff);
    iLui  = itype(6'b001111, 0, 7, 16'h1234);
    iLw   = itype(6'b100011, 0, 5, 16'd8);
    iSw   = itype(6'b101011, 0, 5, 16'd12);
    iBeq  = itype(6'b000100, 1, 2, 16'h0004);
    iJal  = {6'b000011, 26'h0000100};
    iJr   = rtype(31, 0, 0, 6'b001000);
    iMult = rtype(1, 2, 0, 6'b011000);
    iDiv  = rtype(1, 2, 0, 6'b011010);
    iDivu = rtype(1, 2, 0, 6'b011011);
    iMfhi = rtype(0, 0, 4, 6'b010000);
    iMflo = rtype(0, 0, 9, 6'b010010);
    iBad  = 32'hFC000000;

    //     name    grfSlt toReg hilo extOp aluOp aluB mdOp
    addSel("addu",   1,    0,   -1,   -1,    0,    0,  -1);
    addSel("subu",   1,    0,   -1,   -1,    1,    0,  -1);
    addSel("ori",    0,    0,   -1,    1,    3,    1,  -1);
    addSel("lui",    0,    0,   -1,    3,    0,    1,  -1);
    addSel("lw",     0,    1,   -1,    0,    0,    1,  -1);
    addSel("sw",    -1,   -1,   -1,    0,    0,    1,  -1);
    addSel("beq",   -1,   -1,   -1,   -1,    1,    0,  -1);
    addSel("jal",    2,    2,   -1,   -1,   -1,   -1,  -1);
    addSel("mult",  -1,   -1,   -1,   -1,   -1,   -1,   0);
    addSel("div",   -1,   -1,   -1,   -1,   -1,   -1,   2);
    addSel("divu",  -1,   -1,   -1,   -1,   -1,   -1,   3);
    addSel("mfhi",   1,    3,    1,   -1,   -1,   -1,  -1);
    addSel("mflo",   1,    3,    0,   -1,   -1,   -1,  -1);

    addRow("rstHold", 1'b1, iAddu, 1'b0, 3'd0, 6'b000000, -1, -1);
    addAluSeq("addu", iAddu, 0);

    addFetch("lw", iLw);
    addRow("lw.D", 1'b0, iLw, 1'b0, 3'd1, 6'b000000, -1, -1);
    addRow("lw.E", 1'b0, iLw, 1'b0, 3'd2, 6'b000000, -1, -1);
    addRow("lw.M", 1'b0, iLw, 1'b0, 3'd3, 6'b000000, -1, -1);
    addRow("lw.W", 1'b0, iLw, 1'b0, 3'd4, 6'b001000, -1, 4);

    addFetch("sw", iSw);
    addRow("sw.D", 1'b0, iSw, 1'b0, 3'd1, 6'b000000, -1, -1);
    addRow("sw.E", 1'b0, iSw, 1'b0, 3'd2, 6'b000000, -1, -1);
    addRow("sw.M", 1'b0, iSw, 1'b0, 3'd3, 6'b000100, -1, 5);

    addFetch("beqT", iBeq);
    addRow("beqT.D", 1'b0, iBeq, 1'b1, 3'd1, 6'b000000, -1, -1);
    addRow("beqT.E", 1'b0, iBeq, 1'b1, 3'd2, 6'b010000, 1, 6);
    addFetch("beqN", iBeq);
    addRow("beqN.D", 1'b0, iBeq, 1'b0, 3'd1, 6'b000000, -1, -1);
    addRow("beqN.E", 1'b0, iBeq, 1'b0, 3'd2, 6'b000000, 1, 6);

    addFetch("jal", iJal);
    addRow("jal.D", 1'b0, iJal, 1'b0, 3'd1, 6'b011000, 2, 7);
    addFetch("jr", iJr);
    addRow("jr.D", 1'b0, iJr, 1'b0, 3'd1, 6'b010000, 3, -1);

    addMdSeq("mult", iMult, 8, 5);
    addMdSeq("div", iDiv, 9, 10);
    addAluSeq("mfhi", iMfhi, 11);
    addAluSeq("mflo", iMflo, 12);
    addAluSeq("subu", iSubu, 1);
    addAluSeq("ori", iOri, 2);
    addAluSeq("lui", iLui, 3);

    addFetch("bad", iBad);
    addRow("bad.D", 1'b0, iBad, 1'b0, 3'd1, 6'b000000, -1, -1);
    addRow("rstF", 1'b1, iAddu, 1'b0, 3'd0, 6'b000000, -1, -1);

    addMdSeq("divuRst", iDivu, 10, 2);
    addRow("divuRst.MD2", 1'b1, iDivu, 1'b0, 3'd5, 6'b000001, -1, -1);
    addAluSeq("after", iAddu, 0);

    reset     = 1'b1;
    bus.instr = 32'h0;
    bus.zero  = 1'b0;
    @(posedge clk);

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      applyStimulus(rows[i]);
      #1;
      checkOutput(rows[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
